// File: rtl/handshake_cmpi_pipe_if.sv
// Handshake bundle for handshake_cmpi_pipe: the two operand channels and the result channel.
// The master side belongs to the producers/consumer; the slave side is the comparator itself.
interface handshake_cmpi_pipe_if #(
  parameter int DATA_TYPE = 32
);
  logic [DATA_TYPE-1:0] lhs;
  logic                 lhs_valid;
  logic                 lhs_ready;
  logic [DATA_TYPE-1:0] rhs;
  logic                 rhs_valid;
  logic                 rhs_ready;
  logic                 result;
  logic                 result_valid;
  logic                 result_ready;

  modport master (
    output lhs, lhs_valid, rhs, rhs_valid, result_ready,
    input  lhs_ready, rhs_ready, result, result_valid
  );

  modport slave (
    input  lhs, lhs_valid, rhs, rhs_valid, result_ready,
    output lhs_ready, rhs_ready, result, result_valid
  );
endinterface

// File: rtl/handshake_cmpi_pipe.sv
// Elastic integer comparator: joins lhs/rhs tokens, evaluates one compile-time predicate
// and carries the 1-bit outcome through LATENCY elastic register stages.
// Optional feature macro: CMPI_PIPE_SKID_EN adds a 2-entry skid buffer after the last
// stage so that the ready seen by the producers is a register.
module handshake_cmpi_pipe #(
  parameter int DATA_TYPE = 32,
  parameter int PREDICATE = 0,
  parameter int LATENCY   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  handshake_cmpi_pipe_if.slave cmp
);

  if (DATA_TYPE < 1) begin : g_bad_width
    $error("handshake_cmpi_pipe: DATA_TYPE must be >= 1");
  end
  if (PREDICATE < 0 || PREDICATE > 9) begin : g_bad_predicate
    $error("handshake_cmpi_pipe: PREDICATE must be 0..9");
  end
  if (LATENCY < 0 || LATENCY > 4) begin : g_bad_latency
    $error("handshake_cmpi_pipe: LATENCY must be 0..4");
  end

  logic [DATA_TYPE-1:0] op_a;
  logic [DATA_TYPE-1:0] op_b;
  logic                 cmp_res;
  logic                 in_v;
  logic                 in_r;
  logic                 in_ready;
  logic                 pipe_v;
  logic                 pipe_r;
  logic                 pipe_ready;

  assign op_a = cmp.lhs;
  assign op_b = cmp.rhs;

  // Predicate evaluation; signed forms treat the operand bits as two's complement.
  always_comb begin
    cmp_res = 1'b0;
    case (PREDICATE)
      0: cmp_res = (op_a == op_b);
      1: cmp_res = (op_a != op_b);
      2: cmp_res = ($signed(op_a) <  $signed(op_b));
      3: cmp_res = ($signed(op_a) <= $signed(op_b));
      4: cmp_res = ($signed(op_a) >  $signed(op_b));
      5: cmp_res = ($signed(op_a) >= $signed(op_b));
      6: cmp_res = (op_a <  op_b);
      7: cmp_res = (op_a <= op_b);
      8: cmp_res = (op_a >  op_b);
      9: cmp_res = (op_a >= op_b);
      default: cmp_res = 1'b0;
    endcase
  end

  // Join: a token exists only when both operands are present; the outcome is masked so
  // that an empty slot always carries result=0.
  assign in_v          = cmp.lhs_valid & cmp.rhs_valid;
  assign in_r          = in_v & cmp_res;
  assign cmp.lhs_ready = cmp.rhs_valid & in_ready;
  assign cmp.rhs_ready = cmp.lhs_valid & in_ready;

  if (LATENCY == 0) begin : g_comb
    assign pipe_v   = in_v;
    assign pipe_r   = in_r;
    assign in_ready = pipe_ready;
  end else begin : g_pipe
    logic [LATENCY-1:0] v_q;
    logic [LATENCY-1:0] r_q;
    logic [LATENCY-1:0] stg_ready;
    logic [LATENCY-1:0] up_v;
    logic [LATENCY-1:0] up_r;
    logic               chain;

    // Stage i may load when it, or any stage after it, has a hole or the sink pulls.
    // Written as a running OR from the output end so the chain has no vector self-loop.
    always_comb begin
      stg_ready = '0;
      chain     = pipe_ready;
      for (int i = LATENCY - 1; i >= 0; i--) begin
        chain        = ~v_q[i] | chain;
        stg_ready[i] = chain;
      end
    end

    // Upstream view of every stage: the join feeds stage 0, stage i-1 feeds stage i.
    always_comb begin
      up_v    = '0;
      up_r    = '0;
      up_v[0] = in_v;
      up_r[0] = in_r;
      for (int i = 1; i < LATENCY; i++) begin
        up_v[i] = v_q[i-1];
        up_r[i] = r_q[i-1];
      end
    end

    // Elastic stage registers; a stalled stage keeps both valid and outcome.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        v_q <= '0;
        r_q <= '0;
      end else begin
        for (int i = 0; i < LATENCY; i++) begin
          if (stg_ready[i]) begin
            v_q[i] <= up_v[i];
            r_q[i] <= up_r[i];
          end
        end
      end
    end

    assign in_ready = stg_ready[0];
    assign pipe_v   = v_q[LATENCY-1];
    assign pipe_r   = r_q[LATENCY-1];
  end

`ifdef CMPI_PIPE_SKID_EN
  logic [1:0] skid_cnt;
  logic [1:0] skid_cnt_nxt;
  logic [1:0] skid_r;
  logic [1:0] skid_r_nxt;
  logic       ready_q;
  logic       push;
  logic       pop;
  logic       out_v;
  logic       out_r;

  // Empty skid is bypassed so latency is unchanged; otherwise the oldest entry is shown.
  assign out_v      = (skid_cnt != 2'd0) | pipe_v;
  assign out_r      = (skid_cnt != 2'd0) ? skid_r[0] : pipe_r;
  assign push       = pipe_v & ready_q;
  assign pop        = out_v & cmp.result_ready;
  assign pipe_ready = ready_q;

  // Next skid occupancy: a bypassed token that is popped at once never gets stored.
  always_comb begin
    skid_cnt_nxt = skid_cnt;
    skid_r_nxt   = skid_r;
    case (skid_cnt)
      2'd0: begin
        if (push && !pop) begin
          skid_r_nxt[0] = pipe_r;
          skid_cnt_nxt  = 2'd1;
        end
      end
      2'd1: begin
        if (push && pop) begin
          skid_r_nxt[0] = pipe_r;
        end else if (push) begin
          skid_r_nxt[1] = pipe_r;
          skid_cnt_nxt  = 2'd2;
        end else if (pop) begin
          skid_r_nxt[0] = 1'b0;
          skid_cnt_nxt  = 2'd0;
        end
      end
      default: begin
        if (pop) begin
          skid_r_nxt   = {1'b0, skid_r[1]};
          skid_cnt_nxt = 2'd1;
        end
      end
    endcase
  end

  // Skid state plus the registered "not full" that gates the pipeline.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      skid_cnt <= 2'd0;
      skid_r   <= 2'b00;
      ready_q  <= 1'b1;
    end else begin
      skid_cnt <= skid_cnt_nxt;
      skid_r   <= skid_r_nxt;
      ready_q  <= (skid_cnt_nxt != 2'd2);
    end
  end

  assign cmp.result_valid = out_v;
  assign cmp.result       = out_r;
`else
  assign pipe_ready       = cmp.result_ready;
  assign cmp.result_valid = pipe_v;
  assign cmp.result       = pipe_r;
`endif

endmodule

// File: tb/tb_handshake_cmpi_pipe.sv
// Bench for handshake_cmpi_pipe: a LATENCY=3 signed-less-than instance checked against a
// token queue model, plus ten LATENCY=0 instances (one per predicate) for the compare table.
module tb_handshake_cmpi_pipe;
  localparam int W    = 8;
  localparam int LAT  = 3;
  localparam int PRED = 2;
`ifdef CMPI_PIPE_SKID_EN
  localparam int CAP  = LAT + 2;
`else
  localparam int CAP  = LAT;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  handshake_cmpi_pipe_if #(.DATA_TYPE(W)) m_if ();

  handshake_cmpi_pipe #(
    .DATA_TYPE (W),
    .PREDICATE (PRED),
    .LATENCY   (LAT)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .cmp (m_if)
  );

  logic [W-1:0] p_lhs, p_rhs;
  logic         p_lv, p_rv, p_rr;
  logic [9:0]   pred_res, pred_val, pred_lr;

  for (genvar p = 0; p < 10; p++) begin : g_pred
    handshake_cmpi_pipe_if #(.DATA_TYPE(W)) pi ();
    assign pi.lhs          = p_lhs;
    assign pi.rhs          = p_rhs;
    assign pi.lhs_valid    = p_lv;
    assign pi.rhs_valid    = p_rv;
    assign pi.result_ready = p_rr;
    assign pred_res[p]     = pi.result;
    assign pred_val[p]     = pi.result_valid;
    assign pred_lr[p]      = pi.lhs_ready;
    handshake_cmpi_pipe #(
      .DATA_TYPE (W),
      .PREDICATE (p),
      .LATENCY   (0)
    ) u_pred (
      .clk (clk),
      .rst (rst),
      .cmp (pi)
    );
  end

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic pred_model(input int p, input logic [W-1:0] a, input logic [W-1:0] b);
    int ua, ub, sa, sb;
    ua = int'(a);
    ub = int'(b);
    sa = (ua >= (1 << (W - 1))) ? ua - (1 << W) : ua;
    sb = (ub >= (1 << (W - 1))) ? ub - (1 << W) : ub;
    case (p)
      0: return ua == ub;
      1: return ua != ub;
      2: return sa <  sb;
      3: return sa <= sb;
      4: return sa >  sb;
      5: return sa >= sb;
      6: return ua <  ub;
      7: return ua <= ub;
      8: return ua >  ub;
      default: return ua >= ub;
    endcase
  endfunction

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    int           t;
  } tok_t;

  tok_t q[$];
  int   cyc       = 0;
  int   next_ok   = 0;
  int   delivered = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: tokens in flight, oldest first. A token is visible LAT cycles after its
  // accept, but never before the cycle after its predecessor left.
  always @(negedge clk) begin
    int  lim;
    logic exp_v;
    if (!rst) begin
      q.delete();
      next_ok = 0;
      check_val("rst_valid", m_if.result_valid, 0);
      check_val("rst_result", m_if.result, 0);
      check_val("rst_lready", m_if.lhs_ready, m_if.rhs_valid);
    end else begin
      exp_v = 1'b0;
      if (q.size() > 0) begin
        lim = q[0].t + LAT;
        if (next_ok > lim) lim = next_ok;
        exp_v = (cyc >= lim);
      end
      check_val("out_valid", m_if.result_valid, exp_v);
`ifndef CMPI_PIPE_SKID_EN
      check_val("lhs_ready", m_if.lhs_ready, m_if.rhs_valid & ((q.size() < LAT) | m_if.result_ready));
      check_val("rhs_ready", m_if.rhs_ready, m_if.lhs_valid & ((q.size() < LAT) | m_if.result_ready));
`endif
      if (m_if.result_valid && m_if.result_ready && q.size() > 0) begin
        check_val("result", m_if.result, pred_model(PRED, q[0].a, q[0].b));
        void'(q.pop_front());
        next_ok = cyc + 1;
        delivered++;
      end
      if (m_if.lhs_valid && m_if.lhs_ready) begin
        check_val("join_pair", m_if.rhs_valid & m_if.rhs_ready, 1);
        q.push_back('{a: m_if.lhs, b: m_if.rhs, t: cyc});
      end
    end
  end

  task automatic drive(input logic lv, input logic rv, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic rr);
    @(posedge clk);
    #1;
    m_if.lhs_valid    = lv;
    m_if.rhs_valid    = rv;
    m_if.lhs          = a;
    m_if.rhs          = b;
    m_if.result_ready = rr;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, '0, '0, 1'b1);
  endtask

  task automatic pred_vec(input logic [W-1:0] a, input logic [W-1:0] b, input logic rr);
    @(posedge clk);
    #1;
    p_lhs = a;
    p_rhs = b;
    p_lv  = 1'b1;
    p_rv  = 1'b1;
    p_rr  = rr;
    @(negedge clk);
    for (int p = 0; p < 10; p++) begin
      check_val($sformatf("pred%0d_res", p), pred_res[p], pred_model(p, a, b));
      check_val($sformatf("pred%0d_valid", p), pred_val[p], 1);
      check_val($sformatf("pred%0d_lready", p), pred_lr[p], rr);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, idx, c, first_cyc;
    logic [W-1:0] ta[100], tb[100];

    m_if.lhs_valid = 1'b0; m_if.rhs_valid = 1'b0;
    m_if.lhs = '0; m_if.rhs = '0; m_if.result_ready = 1'b1;
    p_lhs = '0; p_rhs = '0; p_lv = 1'b0; p_rv = 1'b0; p_rr = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // Predicate table, including the boundary vectors.
    pred_vec(8'hFF, 8'h01, 1'b1);
    check_val("ff01_slt", pred_res[2], 1);
    check_val("ff01_ult", pred_res[6], 0);
    check_val("ff01_sge", pred_res[5], 0);
    check_val("ff01_uge", pred_res[9], 1);
    check_val("ff01_eq",  pred_res[0], 0);
    check_val("ff01_ne",  pred_res[1], 1);
    pred_vec(8'h80, 8'h80, 1'b1);
    check_val("8080_eq",  pred_res[0], 1);
    check_val("8080_sle", pred_res[3], 1);
    check_val("8080_ugt", pred_res[8], 0);
    pred_vec(8'h7F, 8'h80, 1'b0);
    pred_vec(8'h00, 8'hFF, 1'b1);
    for (int i = 0; i < 20; i++) pred_vec(W'($urandom), W'($urandom), 1'($urandom));

    // Join: lhs alone never produces a token; one token once rhs arrives.
    d0 = delivered;
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 8'h05, 8'h09, 1'b1);
    drive(1'b1, 1'b1, 8'h05, 8'h09, 1'b1);
    idle_cycles(LAT + 3);
    check_val("join_one", delivered - d0, 1);

    // Back-pressure: 10 back-to-back tokens, sink stalled for relative cycles 4..9.
    d0 = delivered;
    idx = 0;
    c = 0;
    while (idx < 10 && c < 200) begin
      drive(1'b1, 1'b1, W'(idx * 37 + 3), W'(200 - idx * 29), !(c >= 4 && c <= 9));
      @(negedge clk);
      if (c == 9) check_val("bp_held", q.size(), CAP);
      if (m_if.lhs_valid && m_if.lhs_ready) idx++;
      c++;
    end
    check_val("bp_sent", idx, 10);
    c = 0;
    while (delivered - d0 < 10 && c < 50) begin
      idle_cycles(1);
      c++;
    end
    check_val("bp_count", delivered - d0, 10);

    // Throughput: 100 continuous pairs with the sink always ready.
    for (int i = 0; i < 100; i++) begin
      ta[i] = W'($urandom);
      tb[i] = W'($urandom);
    end
    d0 = delivered;
    idx = 0;
    c = 0;
    first_cyc = 0;
    while (idx < 100 && c < 300) begin
      drive(1'b1, 1'b1, ta[idx], tb[idx], 1'b1);
      @(negedge clk);
      if (m_if.lhs_valid && m_if.lhs_ready) begin
        if (idx == 0) first_cyc = cyc;
        idx++;
      end
      c++;
    end
    check_val("tp_accept_cycles", c, 100);
    c = 0;
    while (delivered - d0 < 100 && c < 50) begin
      idle_cycles(1);
      c++;
    end
    check_val("tp_count", delivered - d0, 100);
    check_val("tp_last", (next_ok - 1) - first_cyc, LAT + 99);

    // Random traffic with random back-pressure.
    for (int i = 0; i < 300; i++)
      drive(($urandom_range(3) != 0), ($urandom_range(3) != 0), W'($urandom), W'($urandom),
            1'($urandom));
    idle_cycles(CAP + 6);
    check_val("rand_drained", q.size(), 0);

    // Reset while full and stalled: outputs drop at once, nothing stale afterwards.
    for (int i = 0; i < CAP + 3; i++) drive(1'b1, 1'b1, W'(i + 100), 8'h7F, 1'b0);
    @(negedge clk);
    check_val("pre_rst_full", q.size(), CAP);
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check_val("rst_now_valid", m_if.result_valid, 0);
    check_val("rst_now_result", m_if.result, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    m_if.lhs_valid = 1'b0;
    m_if.rhs_valid = 1'b0;
    m_if.result_ready = 1'b1;
    d0 = delivered;
    idle_cycles(CAP + 4);
    check_val("post_rst_none", delivered - d0, 0);
    drive(1'b1, 1'b1, 8'h80, 8'h01, 1'b1);
    idle_cycles(CAP + 3);
    check_val("post_rst_one", delivered - d0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
